// File: rtl/m_mem_port.sv
// M-stage data-memory port: issues one request/ack bus access per load/store,
// stalls the pipeline while it is outstanding, and aligns/extends the data.
module m_mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_in,
  input  logic [31:0] Result_in,
  input  logic [31:0] FWRD2rt_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        addr_err,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  // Compared against the pre-increment count, so the last REQ cycle is the TIMEOUT-th.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;

  logic        is_load, is_store, is_mem, sext, aligned;
  logic [1:0]  size;
  logic [1:0]  a;
  logic [3:0]  be;
  logic [31:0] wdata, ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        unused_instr;

  assign a            = Result_in[1:0];
  assign is_mem       = is_load | is_store;
  assign unused_instr = ^Instr_in[25:0];

  // size: 0 = byte, 1 = half, 2 = word
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = 2'd0;
    case (Instr_in[31:26])
      6'h20: begin is_load  = 1'b1; sext = 1'b1; size = 2'd0; end
      6'h21: begin is_load  = 1'b1; sext = 1'b1; size = 2'd1; end
      6'h23: begin is_load  = 1'b1;              size = 2'd2; end
      6'h24: begin is_load  = 1'b1;              size = 2'd0; end
      6'h25: begin is_load  = 1'b1;              size = 2'd1; end
      6'h28: begin is_store = 1'b1;              size = 2'd0; end
      6'h29: begin is_store = 1'b1;              size = 2'd1; end
      6'h2B: begin is_store = 1'b1;              size = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    rbyte   = mem_rdata[{a, 3'b000} +: 8];
    rhalf   = a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    aligned = 1'b1;
    be      = 4'b0001 << a;
    wdata   = {4{FWRD2rt_in[7:0]}};
    ext     = {{24{sext & rbyte[7]}}, rbyte};
    case (size)
      2'd2: begin
        aligned = (a == 2'b00);
        be      = 4'b1111;
        wdata   = FWRD2rt_in;
        ext     = mem_rdata;
      end
      2'd1: begin
        aligned = ~a[0];
        be      = a[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{FWRD2rt_in[15:0]}};
        ext     = {{16{sext & rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    mem_req     = 1'b0;
    stall       = 1'b0;
    addr_err    = 1'b0;
    bus_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem && aligned) begin
          mem_req = 1'b1;
          stall   = 1'b1;
          cnt_d   = 8'd0;
          state_d = REQ;
        end else if (is_mem) begin
          addr_err = 1'b1;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack) begin
          if (is_load) load_data_d = ext;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          bus_err = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Always leave DONE so the instruction still sitting on Instr_in is not re-issued.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The flops clear asynchronously, but IDLE would re-request off a held instruction.
    if (reset) begin
      mem_req  = 1'b0;
      stall    = 1'b0;
      addr_err = 1'b0;
      bus_err  = 1'b0;
    end
  end

  assign mem_we    = mem_req & is_store;
  assign mem_addr  = mem_req ? {Result_in[31:2], 2'b00} : 32'd0;
  assign mem_be    = mem_req ? be : 4'd0;
  assign mem_wdata = (mem_req && is_store) ? wdata : 32'd0;
  assign load_data = load_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end
endmodule
